// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes,
// FSM encodings, write-beat payload and byte-strobe merge.
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] WIDLE = 1'b0;
  localparam logic [0:0] WRESP = 1'b1;
  localparam logic [0:0] RIDLE = 1'b0;
  localparam logic [0:0] RDATA = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_beat_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite responder holding NUM_REGS 32-bit registers, with per-register
// write pulses and SLVERR on out-of-range accesses.
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [STRB_W-1:0]               S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  logic [0:0]                         wstate_q, wstate_d;
  logic [0:0]                         rstate_q, rstate_d;
  logic                               awready_q, awready_d;
  logic                               wready_q, wready_d;
  logic                               arready_q, arready_d;
  logic                               aw_full_q, aw_full_d;
  logic                               w_full_q, w_full_d;
  logic [ADDR_W-1:0]                  aw_hold_q, aw_hold_d;
  w_beat_t                            w_hold_q, w_hold_d;
  logic                               bvalid_q, bvalid_d;
  logic [1:0]                         bresp_q, bresp_d;
  logic                               rvalid_q, rvalid_d;
  logic [1:0]                         rresp_q, rresp_d;
  logic [DATA_W-1:0]                  rdata_q, rdata_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d;

  logic                               aw_hs, w_hs, ar_hs;
  logic [ADDR_W-1:0]                  wr_addr;
  w_beat_t                            wr_beat;
  logic [IDX_W-1:0]                   w_idx, r_idx;
  logic                               unused_c;

  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

  // Write path: independent AW/W capture, commit as soon as both are present.
  always_comb begin
    wstate_d   = wstate_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_hold_d  = aw_hold_q;
    w_hold_d   = w_hold_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    aw_hs   = S_AXI_AWVALID && awready_q;
    w_hs    = S_AXI_WVALID && wready_q;
    wr_addr = aw_full_q ? aw_hold_q : S_AXI_AWADDR;
    wr_beat = w_full_q ? w_hold_q : w_beat_t'{data: S_AXI_WDATA, strb: S_AXI_WSTRB};
    w_idx   = wr_addr[ADDR_W-1:2];

    case (wstate_q)
      WIDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_hold_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_hold_d = wr_beat;
        end
        if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (32'(w_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = WRESP;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
              regs_d[i]     = strb_merge(regs_q[i], wr_beat.data, wr_beat.strb);
              wr_pulse_d[i] = 1'b1;
            end
          end
        end
      end
      WRESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = WIDLE;
        end
      end
      default: wstate_d = WIDLE;
    endcase

    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  // Read path: sample register (pre-write value) on AR handshake.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    ar_hs = S_AXI_ARVALID && arready_q;
    r_idx = S_AXI_ARADDR[ADDR_W-1:2];

    case (rstate_q)
      RIDLE: begin
        if (ar_hs) begin
          rvalid_d = 1'b1;
          rstate_d = RDATA;
          rresp_d  = (32'(r_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          rdata_d  = '0;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) rdata_d = regs_q[i];
          end
        end
      end
      RDATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = RIDLE;
        end
      end
      default: rstate_d = RIDLE;
    endcase

    arready_d = !rvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q   <= WIDLE;
      rstate_q   <= RIDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_hold_q  <= '0;
      w_hold_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_hold_q  <= aw_hold_d;
      w_hold_q   <= w_hold_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_q         = regs_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_axi_lite_slave_regfile;

  localparam int unsigned NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]      awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [32*NR-1:0] reg_q;
  logic [NR-1:0]   pulse;

  axi_lite_slave_regfile #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(NR)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(pulse)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: pending AW/W, outstanding B and R, register array.
  logic [31:0]   m_regs [NR];
  logic          m_ready_en, m_aw_pend, m_w_pend, m_bvalid, m_rvalid;
  logic [5:0]    m_aw_addr;
  logic [31:0]   m_w_data, m_rdata;
  logic [3:0]    m_w_strb;
  logic [1:0]    m_bresp, m_rresp;
  logic [NR-1:0] m_pulse;
  logic          m_aw_took, m_w_took, m_ar_took;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ready_en = 0; m_aw_pend = 0; m_w_pend = 0; m_bvalid = 0; m_rvalid = 0;
    m_aw_addr = '0; m_w_data = '0; m_w_strb = '0; m_rdata = '0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_pulse = '0;
    m_aw_took = 0; m_w_took = 0; m_ar_took = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin : model_p
    int unsigned idx;
    if (!rst_n) model_reset();
    else begin
      m_aw_took = awvalid && m_ready_en && !m_aw_pend && !m_bvalid;
      m_w_took  = wvalid && m_ready_en && !m_w_pend && !m_bvalid;
      m_ar_took = arvalid && m_ready_en && !m_rvalid;
      m_pulse = '0;
      if (m_rvalid && rready) m_rvalid = 0;
      if (m_bvalid && bready) m_bvalid = 0;
      if (m_ar_took) begin
        idx = 32'(araddr[5:2]);
        m_rvalid = 1;
        m_rdata  = (idx < NR) ? m_regs[idx[2:0]] : 32'h0;
        m_rresp  = (idx < NR) ? 2'b00 : 2'b10;
      end
      if (m_aw_took) begin m_aw_pend = 1; m_aw_addr = awaddr; end
      if (m_w_took)  begin m_w_pend = 1; m_w_data = wdata; m_w_strb = wstrb; end
      if (m_aw_pend && m_w_pend) begin
        idx = 32'(m_aw_addr[5:2]);
        if (idx < NR) begin
          m_regs[idx[2:0]]  = merge(m_regs[idx[2:0]], m_w_data, m_w_strb);
          m_pulse[idx[2:0]] = 1'b1;
          m_bresp = 2'b00;
        end else m_bresp = 2'b10;
        m_bvalid = 1; m_aw_pend = 0; m_w_pend = 0;
      end
      m_ready_en = 1;
    end
  end

  always @(negedge clk) begin : compare_p
    logic [32*NR-1:0] flat;
    for (int i = 0; i < NR; i++) flat[32*i +: 32] = m_regs[i];
    chk("awready", 256'(awready), 256'(m_ready_en && !m_aw_pend && !m_bvalid));
    chk("wready",  256'(wready),  256'(m_ready_en && !m_w_pend && !m_bvalid));
    chk("arready", 256'(arready), 256'(m_ready_en && !m_rvalid));
    chk("bvalid",  256'(bvalid),  256'(m_bvalid));
    chk("rvalid",  256'(rvalid),  256'(m_rvalid));
    chk("reg_q",   256'(reg_q),   256'(flat));
    chk("pulse",   256'(pulse),   256'(m_pulse));
    if (m_bvalid) chk("bresp", 256'(bresp), 256'(m_bresp));
    if (m_rvalid) begin
      chk("rdata", 256'(rdata), 256'(m_rdata));
      chk("rresp", 256'(rresp), 256'(m_rresp));
    end
  end

  task automatic wr_same(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] exp_resp, input logic [7:0] exp_pulse,
                         input string tag);
    @(negedge clk);
    chk({tag, "_awready"}, 256'(awready), 256'(1'b1));
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk({tag, "_bvalid"}, 256'(bvalid), 256'(1'b1));
    chk({tag, "_bresp"}, 256'(bresp), 256'(exp_resp));
    chk({tag, "_pulse"}, 256'(pulse), 256'(exp_pulse));
    @(negedge clk);
    chk({tag, "_pulse_off"}, 256'(pulse), 256'(8'h00));
    chk({tag, "_bvalid_off"}, 256'(bvalid), 256'(1'b0));
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                    input string tag);
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    chk({tag, "_rvalid"}, 256'(rvalid), 256'(1'b1));
    chk({tag, "_rdata"}, 256'(rdata), 256'(exp_d));
    chk({tag, "_rresp"}, 256'(rresp), 256'(exp_r));
    @(negedge clk);
    chk({tag, "_rvalid_off"}, 256'(rvalid), 256'(1'b0));
  endtask

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;

    repeat (3) @(negedge clk);
    chk("rst_readies", 256'({awready, wready, arready}), 256'(3'b000));
    chk("rst_valids", 256'({bvalid, rvalid}), 256'(2'b00));
    chk("rst_resp_data", 256'({bresp, rresp, rdata}), 256'(36'h0));
    chk("rst_regs", 256'(reg_q), 256'(0));
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 256'({awready, wready, arready}), 256'(3'b111));

    rd(6'h04, 32'h0, 2'b00, "rd_reset");

    wr_same(6'h08, 32'hDEADBEEF, 4'hF, 2'b00, 8'h04, "wr_same");
    chk("reg2", 256'(reg_q[95:64]), 256'(32'hDEADBEEF));

    // W three cycles ahead of AW, partial strobe
    wr_same(6'h0C, 32'hAABBCCDD, 4'hF, 2'b00, 8'h08, "wr_pre");
    @(negedge clk);
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("w_first_no_b", 256'(bvalid), 256'(1'b0));
    repeat (2) @(negedge clk);
    awaddr = 6'h0C; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("w_first_bvalid", 256'(bvalid), 256'(1'b1));
    chk("w_first_bresp", 256'(bresp), 256'(2'b00));
    chk("w_first_pulse", 256'(pulse), 256'(8'h08));
    chk("w_first_reg3", 256'(reg_q[127:96]), 256'(32'hAA22CC44));
    @(negedge clk);

    wr_same(6'h20, 32'hFFFFFFFF, 4'hF, 2'b10, 8'h00, "wr_oor");
    rd(6'h3C, 32'h0, 2'b10, "rd_oor");

    // B stall; a new AW/W waits until the B handshake
    bready = 0;
    @(negedge clk);
    awaddr = 6'h10; awvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    awaddr = 6'h14; wdata = 32'h12345678;
    chk("stall_bvalid0", 256'(bvalid), 256'(1'b1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_bvalid", 256'(bvalid), 256'(1'b1));
      chk("stall_bresp", 256'(bresp), 256'(2'b00));
      chk("stall_readies", 256'({awready, wready}), 256'(2'b00));
    end
    bready = 1;
    @(negedge clk);
    chk("b_done", 256'(bvalid), 256'(1'b0));
    chk("aw_ready_after_b", 256'(awready), 256'(1'b1));
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("second_bvalid", 256'(bvalid), 256'(1'b1));
    chk("second_pulse", 256'(pulse), 256'(8'h20));
    chk("second_reg5", 256'(reg_q[191:160]), 256'(32'h12345678));
    @(negedge clk);

    // Read and write to the same register on the same edge
    wr_same(6'h00, 32'h1, 4'hF, 2'b00, 8'h01, "wr_old");
    @(negedge clk);
    araddr = 6'h00; arvalid = 1; awaddr = 6'h00; awvalid = 1;
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("rw_rdata_old", 256'(rdata), 256'(32'h1));
    chk("rw_bvalid", 256'(bvalid), 256'(1'b1));
    chk("rw_reg0_new", 256'(reg_q[31:0]), 256'(32'h5));
    @(negedge clk);
    rd(6'h00, 32'h5, 2'b00, "rd_new");

    // Reset while a read response is pending
    @(negedge clk);
    rready = 0; araddr = 6'h04; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("pre_rst_rvalid", 256'(rvalid), 256'(1'b1));
    #2 rst_n = 0;
    #1;
    chk("rst_rvalid_drop", 256'(rvalid), 256'(1'b0));
    chk("rst_arready", 256'(arready), 256'(1'b0));
    chk("rst_regs_clear", 256'(reg_q), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1; rready = 1;
    @(negedge clk);
    chk("ready_after_rst2", 256'({awready, wready, arready}), 256'(3'b111));

    // Randomized traffic; payloads held until accepted
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 2000) begin
        awvalid = 0; wvalid = 0; arvalid = 0;
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end else begin
        if (!awvalid || m_aw_took) begin
          awvalid = ($urandom_range(0, 2) != 0);
          awaddr  = 6'($urandom_range(0, 47));
        end
        if (!wvalid || m_w_took) begin
          wvalid = ($urandom_range(0, 2) != 0);
          wdata  = $urandom;
          wstrb  = 4'($urandom);
        end
        if (!arvalid || m_ar_took) begin
          arvalid = ($urandom_range(0, 1) != 0);
          araddr  = 6'($urandom_range(0, 47));
        end
        bready = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
- AXI4-Lite responder (slave) register file. It terminates transactions issued by the SPI-bridged AXI master.
- Holds NUM_REGS software-visible 32-bit registers and exposes them to fabric logic. Generates a one-cycle write strobe per register.
- Out-of-range accesses receive SLVERR. Read and write channels are independent and may be active in the same cycle.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2**C_S_AXI_ADDR_WIDTH >= 4*NUM_REGS.
NUM_REGS, 8, number of registers; register i sits at byte offset 4*i.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_q  out  32*NUM_REGS  flattened register contents; register i at bits [32*i+31:32*i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - All registers = 0.
  - AWREADY=WREADY=ARREADY=0 during reset; they go high the first cycle after deassertion.
  - BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, reg_wr_pulse=0.
- Write path: state WIDLE / WRESP.
  - AW and W are captured independently into holding registers aw_hold/w_hold, each with a full flag.
  - AWREADY = !aw_full && !BVALID. WREADY = !w_full && !BVALID.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - Commit happens in the cycle where both full flags are set, or both handshakes complete together (bypass of the hold registers):
    - Decode index = addr[ADDR-1:2]; addr[1:0] is ignored.
    - If index < NUM_REGS: update each byte whose WSTRB bit is set, pulse reg_wr_pulse[index] for exactly one cycle, BRESP=00.
    - Otherwise: no register change, no pulse, BRESP=10.
  - BVALID rises on the cycle after the commit edge (write latency 1 cycle after the later of AW/W).
  - Clear both full flags and enter WRESP. Remain there until BVALID && BREADY, then return to WIDLE; AWREADY/WREADY re-assert the next cycle.
  - WSTRB=0 commits with BRESP=00 and leaves the register unchanged; the pulse still fires.
- Read path: state RIDLE / RDATA.
  - ARREADY = !RVALID.
  - On ARVALID && ARREADY, RDATA/RRESP are registered and RVALID=1 the next cycle.
    - In range: RDATA = register value, RRESP=00.
    - Out of range: RDATA=0, RRESP=10.
  - RDATA/RRESP are held stable while RVALID && !RREADY.
  - Max throughput: one read per 2 cycles.
- Simultaneous read and write commit to the same register: the read returns the pre-write value; the write takes effect that edge.
- BVALID/RVALID never drop without the matching READY.
- Reset mid-transaction: all pending state is discarded and no response is issued. The master is reset by the same net.

Decomposition:
- Package axi_lite_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write FSM encoding WIDLE/WRESP; read FSM encoding RIDLE/RDATA.
  - Function for byte-strobe merge.
- Single flat module. Register storage is simple enough that no sub-module is warranted.

Test Plan:
- Reset then read offset 0x04 -> RVALID one cycle after the AR handshake, RDATA=0x00000000, RRESP=00.
- AW=0x08 and W=0xDEADBEEF/STRB=0xF in the same cycle -> BVALID next cycle with BRESP=00, reg_wr_pulse[2] high for 1 cycle, reg_q[95:64]=0xDEADBEEF.
- W=0x11223344 three cycles before AW=0x0C, STRB=0x5 on a register holding 0xAABBCCDD -> result 0xAA22CC44, BRESP=00.
- Write to 0x20 (index 8, NUM_REGS=8) -> BRESP=10, no pulse. Read 0x3C -> RDATA=0, RRESP=10.
- BREADY held low 5 cycles after BVALID -> BVALID, BRESP stable and AWREADY/WREADY=0 throughout; a new AW is accepted only the cycle after the B handshake.
- Read 0x00 and commit write 0x00=0x5 in the same edge with old value 0x1 -> RDATA=0x1, subsequent read=0x5. Assert ARESETN low while RVALID=1 -> RVALID=0 immediately.
